// File: rtl/regfile_sb.sv
// Integer register file with per-register busy scoreboard for long-latency ops.
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int AW        = $clog2(NREGS),
  parameter int NRD       = 2,
  parameter int ZERO_REG0 = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                reg_write,
  input  logic [AW-1:0]       rd,
  input  logic [XLEN-1:0]     wd,
  input  logic                wb_clr,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_val,
  output logic [NRD-1:0]      rs_busy,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_rd,
  output logic                sb_waw,
  output logic [AW:0]         busy_cnt,
  output logic                sb_full
);

  localparam int CW = AW + 1;
  localparam bit Z0 = (ZERO_REG0 != 0);
  localparam logic [AW:0] FULL_CNT = Z0 ? CW'(NREGS - 1) : CW'(NREGS);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [AW:0]      cnt_nxt;
  logic             waw_nxt;
  logic             wr_en;
  logic             set_en;
  logic             clr_en;

  assign wr_en  = reg_write && !(Z0 && rd == '0);
  assign set_en = sb_set && !(Z0 && sb_rd == '0);
  assign clr_en = reg_write && wb_clr;

  // Set is applied after clear so a newly issued producer keeps the reg busy.
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[rd] = 1'b0;
    if (set_en) busy_nxt[sb_rd] = 1'b1;
    cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
    end
    waw_nxt = set_en && busy[sb_rd] && !(clr_en && rd == sb_rd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      busy     <= '0;
      busy_cnt <= '0;
      sb_waw   <= 1'b0;
    end else begin
      if (wr_en) regs[rd] <= wd;
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
      sb_waw   <= waw_nxt;
    end
  end

  assign sb_full = (busy_cnt == FULL_CNT);

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] val;
    logic            bsy;

    assign addr = rs_addr[k*AW +: AW];

    always_comb begin
      val = (Z0 && addr == '0) ? '0 : regs[addr];
      bsy = busy[addr];
`ifdef REGFILE_BYPASS_EN
      // Forward the in-flight writeback so decode sees it without a stall.
      if (wr_en && rd == addr) val = wd;
      if (clr_en && rd == addr && !(sb_set && sb_rd == addr)) bsy = 1'b0;
`endif
    end

    assign rs_val[k*XLEN +: XLEN] = val;
    assign rs_busy[k]             = bsy;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table, corner sequences, random run vs model.
module tb_regfile_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;

  // ---------------- clock / reset / dut ----------------
  logic                clk = 1'b0;
  logic                rst;
  logic                reg_write;
  logic [AW-1:0]       rd;
  logic [XLEN-1:0]     wd;
  logic                wb_clr;
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_val;
  logic [NRD-1:0]      rs_busy;
  logic                sb_set;
  logic [AW-1:0]       sb_rd;
  logic                sb_waw;
  logic [AW:0]         busy_cnt;
  logic                sb_full;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG0(1)) dut (
    .clk(clk), .rst(rst), .reg_write(reg_write), .rd(rd), .wd(wd), .wb_clr(wb_clr),
    .rs_addr(rs_addr), .rs_val(rs_val), .rs_busy(rs_busy), .sb_set(sb_set),
    .sb_rd(sb_rd), .sb_waw(sb_waw), .busy_cnt(busy_cnt), .sb_full(sb_full)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];
  bit              m_waw;
  logic [XLEN-1:0] exp_q [$];

  function automatic int m_cnt();
    int n = 0;
    for (int i = 0; i < NREGS; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic logic [XLEN-1:0] m_val(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (reg_write && rd == a) return wd;
`endif
    return m_regs[a];
  endfunction

  function automatic logic m_bsy(input logic [AW-1:0] a);
`ifdef REGFILE_BYPASS_EN
    if (reg_write && wb_clr && rd == a && !(sb_set && sb_rd == a)) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_waw = 1'b0;
  endtask

  task automatic model_edge();
    bit was, setv, clrv;
    if (rst) begin
      model_reset();
    end else begin
      was  = m_busy[sb_rd];
      setv = sb_set && sb_rd != 0;
      clrv = reg_write && wb_clr;
      if (reg_write && rd != 0) m_regs[rd] = wd;
      if (clrv) m_busy[rd] = 1'b0;
      if (setv) m_busy[sb_rd] = 1'b1;
      m_waw = setv && was && !(clrv && rd == sb_rd);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic we, input logic [AW-1:0] d, input logic [XLEN-1:0] data,
                       input logic clr, input logic set, input logic [AW-1:0] sr,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rst = r; reg_write = we; rd = d; wd = data; wb_clr = clr;
    sb_set = set; sb_rd = sr; rs_addr = {a1, a0};
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, rs_addr[AW-1:0], rs_addr[2*AW-1:AW]);
  endtask

  // One clock: combinational outputs checked against the model before the edge,
  // registered outputs after it.
  task automatic tick();
    #1;
    exp_q.push_back(m_val(rs_addr[AW-1:0]));
    exp_q.push_back(m_val(rs_addr[2*AW-1:AW]));
    check("m_rs_val0", rs_val[XLEN-1:0], exp_q.pop_front());
    check("m_rs_val1", rs_val[2*XLEN-1:XLEN], exp_q.pop_front());
    check("m_rs_busy0", XLEN'(rs_busy[0]), XLEN'(m_bsy(rs_addr[AW-1:0])));
    check("m_rs_busy1", XLEN'(rs_busy[1]), XLEN'(m_bsy(rs_addr[2*AW-1:AW])));
    check("m_sb_full", XLEN'(sb_full), XLEN'(m_cnt() == NREGS - 1));
    @(posedge clk);
    model_edge();
    #1;
    check("m_busy_cnt", XLEN'(busy_cnt), XLEN'(m_cnt()));
    check("m_sb_waw", XLEN'(sb_waw), XLEN'(m_waw));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic rst, we; logic [AW-1:0] rd; logic [XLEN-1:0] wd; logic clr, set;
    logic [AW-1:0] sbrd, a0, a1;
    logic [XLEN-1:0] v0, v1; logic b0, b1; logic [AW:0] cnt; logic waw;
  } vec_t;

  vec_t vecs [13];

  initial begin
    // rst we rd wd clr set sbrd a0 a1 | v0 v1 b0 b1 cnt waw  (observed after the edge)
    vecs[0]  = '{0,1, 5,32'h00000055,0,0, 0, 5, 6, 32'h55,32'h0, 0,0,0,0};
    vecs[1]  = '{1,0, 0,32'h0,       0,0, 0, 5, 6, 32'h0, 32'h0, 0,0,0,0};
    vecs[2]  = '{0,1, 5,32'h0000001F,0,0, 0, 5, 6, 32'h1F,32'h0, 0,0,0,0};
    vecs[3]  = '{0,1, 6,32'h00000006,0,0, 0, 5, 6, 32'h1F,32'h06,0,0,0,0};
    vecs[4]  = '{0,1, 0,32'hDEADBEEF,0,0, 0, 0, 5, 32'h0, 32'h1F,0,0,0,0};
    vecs[5]  = '{0,0, 0,32'h0,       0,1,10,10, 5, 32'h0, 32'h1F,1,0,1,0};
    vecs[6]  = '{0,1,10,32'h00000004,1,0, 0,10, 5, 32'h4, 32'h1F,0,0,0,0};
    vecs[7]  = '{0,0, 0,32'h0,       0,1, 7, 7,10, 32'h0, 32'h4, 1,0,1,0};
    vecs[8]  = '{0,1, 7,32'h00000077,1,1, 7, 7,10, 32'h77,32'h4, 1,0,1,0};
    vecs[9]  = '{0,0, 0,32'h0,       0,1, 7, 7,10, 32'h77,32'h4, 1,0,1,1};
    vecs[10] = '{0,0, 0,32'h0,       0,0, 0, 7,10, 32'h77,32'h4, 1,0,1,0};
    vecs[11] = '{1,1, 5,32'h0000AAAA,0,1, 3, 5, 6, 32'h0, 32'h0, 0,0,0,0};
    vecs[12] = '{0,1, 9,32'h00000099,1,0, 0, 9, 7, 32'h99,32'h0, 0,0,0,0};
  end

  // ---------------- test sequence ----------------
  initial begin
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
    model_reset();
    @(posedge clk); #1;
    check("reset_busy_cnt", XLEN'(busy_cnt), '0);
    check("reset_sb_waw", XLEN'(sb_waw), '0);

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].rst, vecs[i].we, vecs[i].rd, vecs[i].wd, vecs[i].clr,
            vecs[i].set, vecs[i].sbrd, vecs[i].a0, vecs[i].a1);
      tick();
      idle();
      #1;
      check($sformatf("vec%0d_v0", i), rs_val[XLEN-1:0], vecs[i].v0);
      check($sformatf("vec%0d_v1", i), rs_val[2*XLEN-1:XLEN], vecs[i].v1);
      check($sformatf("vec%0d_b0", i), XLEN'(rs_busy[0]), XLEN'(vecs[i].b0));
      check($sformatf("vec%0d_b1", i), XLEN'(rs_busy[1]), XLEN'(vecs[i].b1));
      check($sformatf("vec%0d_cnt", i), XLEN'(busy_cnt), XLEN'(vecs[i].cnt));
      check($sformatf("vec%0d_waw", i), XLEN'(sb_waw), XLEN'(vecs[i].waw));
    end

    // Fill every non-zero register, overflow once, clear one, then reset mid-fill.
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
    tick();
    for (int r = 1; r < NREGS; r++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, AW'(r), AW'(r), '0);
      tick();
    end
    check("fill_cnt", XLEN'(busy_cnt), 32'd31);
    check("fill_full", XLEN'(sb_full), 32'd1);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 5'd5, 5'd5, '0);
    tick();
    check("full_set_waw", XLEN'(sb_waw), 32'd1);
    check("full_set_cnt", XLEN'(busy_cnt), 32'd31);
    drive(1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 1'b0, '0, 5'd4, 5'd5);
    tick();
    check("clr_one_cnt", XLEN'(busy_cnt), 32'd30);
    check("clr_one_full", XLEN'(sb_full), 32'd0);
    check("clr_one_waw", XLEN'(sb_waw), 32'd0);
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 5'd4, 5'd4, 5'd5);
    tick();
    check("midfill_rst_cnt", XLEN'(busy_cnt), 32'd0);
    drive(1'b0, 1'b1, 5'd6, 32'h66, 1'b1, 1'b0, '0, 5'd6, 5'd5);
    tick();
    check("stale_clr_cnt", XLEN'(busy_cnt), 32'd0);

    // Same-cycle write/read of x3, and same-cycle clear/read of a busy reg.
    drive(1'b0, 1'b1, 5'd3, 32'h12345678, 1'b0, 1'b0, '0, 5'd3, 5'd8);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_val", rs_val[XLEN-1:0], 32'h12345678);
`else
    check("nobypass_val", rs_val[XLEN-1:0], 32'h0);
`endif
    tick();
    check("after_write_val", rs_val[XLEN-1:0], 32'h12345678);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 5'd8, 5'd3, 5'd8);
    tick();
    drive(1'b0, 1'b1, 5'd8, 32'h88, 1'b1, 1'b0, '0, 5'd3, 5'd8);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_busy", XLEN'(rs_busy[1]), 32'd0);
`else
    check("nobypass_busy", XLEN'(rs_busy[1]), 32'd1);
`endif
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), AW'($urandom_range(0, NREGS-1)),
            $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            AW'($urandom_range(0, NREGS-1)), AW'($urandom_range(0, NREGS-1)),
            AW'($urandom_range(0, NREGS-1)));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the integer register file, for the RV32IM core.
- Provides XLEN-wide architectural registers with NRD combinational read ports and one write port.
- Adds synchronous reset and a per-register busy scoreboard so long-latency M-extension ops (DIV/REM) can mark destinations pending and decode can detect RAW/WAW hazards.
- Sits between decode (reads, scoreboard set) and writeback (write, scoreboard clear).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers; must be a power of 2, range 2..64
AW, $clog2(NREGS), register index width (derived; do not override)
NRD, 2, number of read ports (1..4)
ZERO_REG0, 1, when 1, register 0 reads 0 and ignores writes and scoreboard sets

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
reg_write  in  1  write enable
rd  in  AW  write index
wd  in  XLEN  write data
wb_clr  in  1  with reg_write: this write retires a scoreboarded op; clears busy[rd]
rs_addr  in  NRD*AW  packed read indices; port k = bits [k*AW +: AW]
rs_val  out  NRD*XLEN  packed read data, combinational
rs_busy  out  NRD  busy[rs_addr[k]] for each port, combinational
sb_set  in  1  mark sb_rd pending
sb_rd  in  AW  index to mark
sb_waw  out  1  registered; pulses 1 cycle when sb_set targets an already-busy reg
busy_cnt  out  AW+1  registered count of set busy bits
sb_full  out  1  combinational; busy_cnt == NREGS-1 (ZERO_REG0=1) or NREGS (ZERO_REG0=0)

Behaviour:
- Reset: while rst=1 at a clk edge, all registers go to 0, busy[] to 0, busy_cnt to 0, sb_waw to 0. Writes and sets in that cycle are ignored.
- Reset mid-operation discards all pending busy bits; a later wb_clr to a non-busy reg is a no-op.
- Write: at posedge, if reg_write and not (ZERO_REG0 and rd==0), regs[rd] <= wd.
  - Write data is visible on reads in the next cycle (unless the bypass feature below is enabled).
- Read: rs_val[k] = regs[rs_addr[k]]. When ZERO_REG0=1, index 0 always reads 0. Out-of-range indices cannot occur (NREGS = 2^AW).
- Scoreboard next state, per register r:
  - set_r = sb_set and sb_rd==r and not (ZERO_REG0 and r==0)
  - clr_r = reg_write and wb_clr and rd==r
  - busy[r] <= set_r ? 1 : (clr_r ? 0 : busy[r])
  - Simultaneous set and clear of the same reg: set wins (a new producer was issued), busy stays 1.
- busy_cnt: registered. Next value = popcount of next busy[].
  - Increments by at most 1 and decrements by at most 1 per cycle.
  - Simultaneous set of reg A and clear of reg B (A != B): count unchanged.
- sb_waw: registered, 1 for exactly one cycle after a set_r where busy[r] was already 1 and clr_r was 0. busy stays 1.
- sb_full: decode must not assert sb_set while sb_full=1. If it does, the set is still applied (it is necessarily WAW) and sb_waw pulses.
- Latency:
  - read: 0 cycles (combinational)
  - write, busy, busy_cnt: 1 cycle
- No simulation $display inside the RTL; debug visibility goes through the bench.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: rs_val[k] = wd when reg_write and rd==rs_addr[k] and not (ZERO_REG0 and rd==0); otherwise the stored value. Likewise rs_busy[k] is forced to 0 when the same cycle's write has wb_clr=1 and rd==rs_addr[k], unless sb_set also targets that reg in that cycle.
- Undefined: reads return stored values only; a same-cycle write becomes visible the next cycle.

Test Plan:
- Reset: preload via writes, assert rst one cycle -> all rs_val=0, busy_cnt=0, sb_waw=0; a write issued with rst=1 is not stored.
- Write/read: write x5=0x0000001F, x6=0x00000006; read ports 0/1 = 5/6 next cycle -> 0x1F / 0x06. Write x0=0xDEADBEEF -> x0 reads 0.
- Scoreboard: sb_set rd=10 -> rs_busy=1 for x10, busy_cnt=1. Write x10=0x00000004 with wb_clr -> next cycle busy=0, busy_cnt=0, rs_val=0x4.
- Simultaneous: x7 busy; same cycle sb_set x7 and write x7 with wb_clr -> busy[7] stays 1, busy_cnt unchanged, sb_waw=0. Second sb_set x7 alone -> sb_waw=1 for one cycle.
- Fill: set every non-zero reg (31 sets) -> busy_cnt=31, sb_full=1. One clear -> busy_cnt=30, sb_full=0. Reset mid-fill -> busy_cnt=0.
- Bypass (REGFILE_BYPASS_EN): write x3=0x12345678 while reading x3 -> same-cycle rs_val=0x12345678. Without the macro, the same cycle returns the old value.
